// File: rtl/interp_sequencer_if.sv
// Upstream sample handshake into the interpolator sequencer.
interface interp_sequencer_if;
  logic               in_valid;
  logic signed [17:0] in_data;
  logic               in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/interp_sequencer.sv
// Fs / 4xFs clock-enable sequencer with a one-deep sample holding register.
// Define INTERP_SEQ_UNDERRUN_ZERO_EN to zero-stuff xkin on underrun instead of repeating it.
module interp_sequencer #(
  parameter int unsigned DIV4X  = 64,
  parameter int unsigned UCNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  interp_sequencer_if.slave   up,
  output logic                clkenin,
  output logic                clken4x,
  output logic signed [17:0]  xkin,
  output logic [1:0]          phase,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_count
);

  localparam int unsigned      CNT_W    = (DIV4X > 1) ? $clog2(DIV4X) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV4X - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               full;
  logic signed [17:0] hold;
  logic               leaving;
  logic               accept;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Pulses decode from state/cnt/phase registers only, never from enable.
  always_comb begin
    state_nx = state;
    clkenin  = 1'b0;
    clken4x  = 1'b0;
    case (state)
      IDLE: if (enable) state_nx = RUN;
      RUN: begin
        clken4x = (cnt == '0);
        clkenin = (cnt == '0) && (phase == 2'd0);
        if (!enable) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign leaving     = (state == RUN) && !enable;
  assign up.in_ready = ~full & ~reset;
  assign accept      = up.in_valid & up.in_ready;

  always_ff @(posedge clock) begin
    if (reset || !enable || state == IDLE) begin
      cnt   <= '0;
      phase <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // A full register is only refilled once clkenin has drained it, so a
  // clkenin edge never both consumes and stores.
  always_ff @(posedge clock) begin
    if (reset) begin
      full           <= 1'b0;
      hold           <= '0;
      xkin           <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= 1'b0;
      if (leaving) begin
        full <= 1'b0;
      end else if (clkenin) begin
        if (full) begin
          xkin <= hold;
          full <= 1'b0;
        end else if (up.in_valid) begin
          xkin <= up.in_data;
        end else begin
          underrun <= 1'b1;
          if (underrun_count != '1) underrun_count <= underrun_count + UCNT_W'(1);
`ifdef INTERP_SEQ_UNDERRUN_ZERO_EN
          xkin <= '0;
`else
          xkin <= xkin;
`endif
        end
      end else if (accept) begin
        hold <= up.in_data;
        full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_interp_sequencer.sv
// Self-checking bench for interp_sequencer against a queue/arithmetic reference model.
// Honours INTERP_SEQ_UNDERRUN_ZERO_EN for the expected underrun fill value.
module tb_interp_sequencer;
  localparam int DIV  = 64;
  localparam int UC   = 8;
  localparam int DIVB = 4;
  localparam int UCB  = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable, reset_b, enable_b;
  logic        clkenin, clken4x, underrun;
  logic [17:0] xkin;
  logic [1:0]  phase;
  logic [7:0]  ucount;
  logic        clkenin_b, clken4x_b, underrun_b;
  logic [17:0] xkin_b;
  logic [1:0]  phase_b;
  logic [1:0]  ucount_b;

  interp_sequencer_if bus();
  interp_sequencer_if bus_b();

  interp_sequencer #(.DIV4X(DIV), .UCNT_W(UC)) dut (
    .clock(clock), .reset(reset), .enable(enable), .up(bus),
    .clkenin(clkenin), .clken4x(clken4x), .xkin(xkin), .phase(phase),
    .underrun(underrun), .underrun_count(ucount));

  interp_sequencer #(.DIV4X(DIVB), .UCNT_W(UCB)) dut_b (
    .clock(clock), .reset(reset_b), .enable(enable_b), .up(bus_b),
    .clkenin(clkenin_b), .clken4x(clken4x_b), .xkin(xkin_b), .phase(phase_b),
    .underrun(underrun_b), .underrun_count(ucount_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time-in-RUN counter plus a one-entry sample queue.
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [17:0] q[$];
  logic [17:0] m_xk = '0;
  int          m_uc = 0;
  bit          m_ur = 1'b0;
  bit          chk_en = 1'b0;

  function automatic bit e_clkin();
    return m_run && (m_t % (4 * DIV)) == 0;
  endfunction
  function automatic bit e_clk4x();
    return m_run && (m_t % DIV) == 0;
  endfunction
  function automatic int e_phase();
    return m_run ? (m_t / DIV) % 4 : 0;
  endfunction

  bit xwin = 1'b0, pwin = 1'b0, uwin = 1'b0;
  int n_xfer = 0, n_in = 0, n_4x = 0, n_ur = 0, n_ur_b = 0;
  int cyc = 0, last_in = -1, last_4x = -1;

  always @(posedge clock) begin
    bit fire;
    if (xwin && bus.in_valid && bus.in_ready) n_xfer++;
    if (reset) begin
      m_run = 1'b0; m_t = 0; q.delete(); m_xk = '0; m_uc = 0; m_ur = 1'b0;
    end else begin
      fire = e_clkin();
      m_ur = 1'b0;
      if (m_run && !enable) q.delete();
      else if (fire) begin
        if (q.size() != 0) m_xk = q.pop_front();
        else if (bus.in_valid) m_xk = bus.in_data;
        else begin
          m_ur = 1'b1;
          if (m_uc < (1 << UC) - 1) m_uc++;
`ifdef INTERP_SEQ_UNDERRUN_ZERO_EN
          m_xk = '0;
`endif
        end
      end else if (bus.in_valid && q.size() == 0) q.push_back(bus.in_data);
      if (enable) begin
        m_t = m_run ? m_t + 1 : 0;
        m_run = 1'b1;
      end else begin
        m_run = 1'b0; m_t = 0;
      end
    end
  end

  always @(posedge clock) begin
    #2;
    cyc++;
    if (chk_en) begin
      check_eq("clkenin", clkenin, e_clkin());
      check_eq("clken4x", clken4x, e_clk4x());
      check_eq("phase", phase, e_phase());
      check_eq("in_ready", bus.in_ready, (q.size() == 0) && !reset);
      check_eq("xkin", xkin, m_xk);
      check_eq("underrun", underrun, m_ur);
      check_eq("underrun_count", ucount, m_uc);
    end
    if (pwin) begin
      if (clkenin) begin
        if (last_in >= 0) check_eq("clkenin_spacing", cyc - last_in, 4 * DIV);
        check_eq("clkenin_with_4x", clken4x, 1);
        last_in = cyc; n_in++;
      end
      if (clken4x) begin
        if (last_4x >= 0) check_eq("clken4x_spacing", cyc - last_4x, DIV);
        check_eq("phase_seq", phase, n_4x % 4);
        last_4x = cyc; n_4x++;
      end
    end
    if (uwin && underrun) n_ur++;
    if (underrun_b) n_ur_b++;
  end

  task automatic send(input logic [17:0] d);
    int g = 0;
    while (!bus.in_ready && g < 2000) begin
      @(negedge clock); g++;
    end
    check_eq("send_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = d;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_clkenin();
    int g = 0;
    do begin
      @(negedge clock); g++;
    end while (!clkenin && g < 2000);
    check_eq("wait_clkenin", clkenin, 1);
  endtask

  task automatic pulse_reset();
    enable = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  logic [17:0] fill;

  initial begin
    reset = 1'b1; enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    reset_b = 1'b1; enable_b = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0;
`ifdef INTERP_SEQ_UNDERRUN_ZERO_EN
    fill = 18'h00000;
`else
    fill = 18'h00123;
`endif
    repeat (10) @(negedge clock);
    chk_en = 1'b1;
    check_eq("rst_clkenin", clkenin, 0);
    check_eq("rst_clken4x", clken4x, 0);
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_xkin", xkin, 0);
    check_eq("rst_ucount", ucount, 0);

    // Pulse timing over 2048 cycles
    reset = 1'b0;
    @(negedge clock);
    enable = 1'b1; pwin = 1'b1;
    repeat (2048) @(negedge clock);
    pwin = 1'b0;
    check_eq("n_clkenin", n_in, 8);
    check_eq("n_clken4x", n_4x, 32);

    // One sample per Fs
    pulse_reset();
    enable = 1'b1;
    send(18'h00100);
    for (int k = 1; k <= 3; k++) begin
      repeat ((k == 1) ? 128 : 256) @(negedge clock);
      send((k % 2 == 1) ? 18'h3FF00 : 18'h00100);
    end
    repeat (200) @(negedge clock);
    check_eq("data_ucount", ucount, 0);
    check_eq("data_xkin", xkin, 18'h3FF00);

    // Bypass in the clkenin cycle
    wait_clkenin();
    bus.in_valid = 1'b1; bus.in_data = 18'h1FFFF;
    @(negedge clock);
    bus.in_valid = 1'b0;
    check_eq("bypass_xkin", xkin, 18'h1FFFF);
    check_eq("bypass_underrun", underrun, 0);

    // Three starved Fs periods
    wait_clkenin();
    bus.in_valid = 1'b1; bus.in_data = 18'h00123;
    @(negedge clock);
    bus.in_valid = 1'b0;
    check_eq("ur_seed_xkin", xkin, 18'h00123);
    n_ur = 0; uwin = 1'b1;
    repeat (3) wait_clkenin();
    @(negedge clock);
    uwin = 1'b0;
    check_eq("ur_pulses", n_ur, 3);
    check_eq("ur_count", ucount, 3);
    check_eq("ur_xkin", xkin, fill);

    // Back-pressure with in_valid held high
    pulse_reset();
    enable = 1'b1; bus.in_valid = 1'b1; n_xfer = 0; xwin = 1'b1;
    repeat (1024) begin
      bus.in_data = 18'($urandom);
      @(negedge clock);
    end
    xwin = 1'b0;
    check_eq("bp_transfers", n_xfer, 5);

    // Abort at cnt=30, phase=2
    begin
      int g = 0;
      do begin
        @(negedge clock); g++;
      end while (!(clken4x && phase == 2'd2) && g < 2000);
      check_eq("abort_sync", phase, 2);
    end
    repeat (30) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check_eq("abort_clkenin", clkenin, 0);
    check_eq("abort_clken4x", clken4x, 0);
    check_eq("abort_full_clear", bus.in_ready, 1);
    repeat (3) @(negedge clock);
    bus.in_valid = 1'b0;
    enable = 1'b1;
    repeat (300) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("midrst_clkenin", clkenin, 0);
    check_eq("midrst_clken4x", clken4x, 0);
    check_eq("midrst_in_ready", bus.in_ready, 0);
    check_eq("midrst_xkin", xkin, 0);
    check_eq("midrst_phase", phase, 0);
    check_eq("midrst_underrun", underrun, 0);
    check_eq("midrst_ucount", ucount, 0);

    // Randomised traffic, enable toggles and occasional reset
    reset = 1'b0;
    enable = 1'b1;
    repeat (4000) begin
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      reset = ($urandom_range(0, 1499) == 0);
      bus.in_valid = ($urandom_range(0, 255) < 2);
      bus.in_data = 18'($urandom);
      @(negedge clock);
    end
    bus.in_valid = 1'b0; reset = 1'b0;

    // Saturation with a 2-bit counter and DIV4X=4
    reset_b = 1'b0; enable_b = 1'b1; n_ur_b = 0;
    repeat (80) @(negedge clock);
    enable_b = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("sat_pulses", n_ur_b, 5);
    check_eq("sat_count", ucount_b, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
